vga_timing_ctrl: RTL and testbench
==================================

# vga_timing_ctrl

Raster timing generator for the 640×480@60 Hz VGA output path. It runs horizontal and vertical counters on the pixel clock, drives `hsync`/`vsync`, and issues pixel coordinates one cycle early so that a registered pattern stage can return `pix_data` in time. It gates the returned RGB565 data onto the output during the active window. It sits directly upstream of the picture generators, which consume `pix_x`/`pix_y` and return `pix_data`, and drives the board VGA connector.

## Interface

Parameters (all 10-bit, counts in pixel clocks or lines):
- `H_SYNC`, default 96: hsync pulse width.
- `H_BACK`, default 48: horizontal back porch.
- `H_VALID`, default 640: active pixels per line.
- `H_FRONT`, default 16: horizontal front porch.
- `V_SYNC`, default 2: vsync pulse width in lines.
- `V_BACK`, default 33: vertical back porch.
- `V_VALID`, default 480: active lines.
- `V_FRONT`, default 10: vertical front porch.
- Derived: `H_TOTAL` = 800 and `V_TOTAL` = 525. These are derived values, not overridable.

Ports:
- `vga_clk`  in  1  pixel clock, 25.175/25 MHz; the only clock.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `pix_data`  in  16  RGB565 from the picture stage; registered there, with 1-cycle latency from `pix_x`/`pix_y`.
- `pix_x`  out  10  requested column, 0..639; 10'h3FF when no request.
- `pix_y`  out  10  requested row, 0..479; 10'h3FF when no request.
- `hsync`  out  1  horizontal sync, active low.
- `vsync`  out  1  vertical sync, active low.
- `rgb`  out  16  pixel to the DAC; 16'h0000 outside the active window.
- `frame_start`  out  1  only with `VGA_TIMING_FRAME_CNT_EN`; see Configuration.
- `frame_cnt`  out  16  only with `VGA_TIMING_FRAME_CNT_EN`; see Configuration.

## Operation

- `cnt_h` counts 0..H_TOTAL-1 and wraps to 0 every cycle after H_TOTAL-1.
- `cnt_v` increments only on the cycle where `cnt_h` == H_TOTAL-1. It wraps 524→0 on that same cycle.
- Horizontal regions, in order: sync 0..95, back porch 96..143, active 144..783, front porch 784..799.
- Vertical regions, in order: sync 0..1, back porch 2..34, active 35..514, front porch 515..524.
- `hsync` = 0 when `cnt_h` < H_SYNC, else 1.
- `vsync` = 0 when `cnt_v` < V_SYNC, else 1.
- `rgb_valid` = (`cnt_h` in 144..783) and (`cnt_v` in 35..514).
- `pix_req` is `rgb_valid` advanced one cycle: (`cnt_h` in 143..782) and (`cnt_v` in 35..514).
- When `pix_req` is high:
  - `pix_x` = `cnt_h` − 143.
  - `pix_y` = `cnt_v` − 35.
- When `pix_req` is low, both `pix_x` and `pix_y` are 10'h3FF.
- `rgb` = `rgb_valid` ? `pix_data` : 16'h0000.
- All arithmetic is unsigned 10-bit. Subtractions are evaluated only inside the request window, so they never underflow.

## Timing

- Only the counters are registered. All outputs are combinational decodes of the counter registers; there is no output register.
- Reset state (asserted asynchronously, immediately on `sys_rst_n` low): `cnt_h` = 0, `cnt_v` = 0. The decode rules then give:
  - `hsync` = 0, `vsync` = 0;
  - `pix_x` = `pix_y` = 10'h3FF;
  - `rgb` = 0;
  - `frame_cnt` = 0, `frame_start` = 0.
- First counter increment occurs on the first `vga_clk` rising edge after `sys_rst_n` deasserts.
- Request/return alignment: a request at cycle N returns `pix_data` at cycle N+1, and that value appears on `rgb` at cycle N+1 with `rgb_valid` high.
  - First pixel: request at `cnt_h` = 143, with `pix_x` = 0.
  - Last pixel: request at `cnt_h` = 782, with `pix_x` = 639.
- Line wrap: `cnt_h` 799→0 and `cnt_v` +1 happen on the same edge.
- Frame wrap: at (`cnt_h` = 799, `cnt_v` = 524) both counters return to 0 on one edge.
- Reset mid-line or mid-frame: counters clear at once and the frame restarts at sync. No partial-line recovery is required.

## Configuration

- `VGA_TIMING_FRAME_CNT_EN` defined:
  - `frame_start` pulses high for exactly one cycle when `cnt_h` = 0 and `cnt_v` = 0, except in the first cycle after reset.
  - `frame_cnt` increments on the edge where the frame wraps (799/524 → 0/0). It wraps from 16'hFFFF to 0.
- Not defined: the `frame_start` and `frame_cnt` ports and their logic are absent.

## Structure

- Package `vga_timing_pkg` holds:
  - H/V sync, back-porch, valid, front-porch and total constants;
  - derived window bounds: active start/end, request start/end;
  - the RGB565 black constant.
- Sub-module `vga_axis_counter`: a parameterised wrapping counter with an increment enable, a terminal-count output, and async active-low clear.
  - Instantiate it twice: horizontal (enable tied to 1) and vertical (enable = horizontal terminal count).

## Test plan

- Reset release, free-run 2 frames: `hsync` low for 96 of every 800 cycles; `vsync` low for exactly 2×800 = 1600 cycles per 420000-cycle frame.
- Request window:
  - first non-3FF `pix_x` = 0 at `cnt_h` = 143, `cnt_v` = 35;
  - last `pix_x` = 639 at `cnt_h` = 782;
  - `pix_y` runs 0..479; exactly 307200 requests per frame.
- Latency: drive `pix_data` = {6'b0, registered `pix_x`}. `rgb` equals column index 0..639 across each active line, and is 0 at `cnt_h` 143 and 784.
- Blanking: hold `pix_data` = 16'hFFFF constantly. `rgb` is 0 in all porches and sync regions, and 16'hFFFF on exactly 640×480 cycles per frame.
- Async reset mid-frame: assert at `cnt_v` = 200, `cnt_h` = 400, between clock edges. Outputs go immediately to `hsync` = 0, `vsync` = 0, `pix_x` = 3FF, `rgb` = 0. After release, timing restarts from `cnt_h` = 0, `cnt_v` = 0.
- With `VGA_TIMING_FRAME_CNT_EN` defined: over 3 frames, `frame_start` pulses exactly 3 times, 420000 cycles apart, and `frame_cnt` reads 3. Preload the counter to 16'hFFFF to confirm it wraps to 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared constants for the 640x480@60 Hz VGA raster timing generator.
// The window bounds below describe the default 640x480 raster; the top
// recomputes the same bounds from its own parameters.
package vga_timing_pkg;

  localparam logic [9:0] H_SYNC_DEF  = 10'd96;
  localparam logic [9:0] H_BACK_DEF  = 10'd48;
  localparam logic [9:0] H_VALID_DEF = 10'd640;
  localparam logic [9:0] H_FRONT_DEF = 10'd16;
  localparam logic [9:0] H_TOTAL_DEF = H_SYNC_DEF + H_BACK_DEF + H_VALID_DEF + H_FRONT_DEF;

  localparam logic [9:0] V_SYNC_DEF  = 10'd2;
  localparam logic [9:0] V_BACK_DEF  = 10'd33;
  localparam logic [9:0] V_VALID_DEF = 10'd480;
  localparam logic [9:0] V_FRONT_DEF = 10'd10;
  localparam logic [9:0] V_TOTAL_DEF = V_SYNC_DEF + V_BACK_DEF + V_VALID_DEF + V_FRONT_DEF;

  // Active window (rgb_valid) and request window (one column earlier).
  localparam logic [9:0] H_ACT_START_DEF = H_SYNC_DEF + H_BACK_DEF;
  localparam logic [9:0] H_ACT_END_DEF   = H_ACT_START_DEF + H_VALID_DEF - 10'd1;
  localparam logic [9:0] H_REQ_START_DEF = H_ACT_START_DEF - 10'd1;
  localparam logic [9:0] H_REQ_END_DEF   = H_ACT_END_DEF - 10'd1;
  localparam logic [9:0] V_ACT_START_DEF = V_SYNC_DEF + V_BACK_DEF;
  localparam logic [9:0] V_ACT_END_DEF   = V_ACT_START_DEF + V_VALID_DEF - 10'd1;

  localparam logic [15:0] RGB565_BLACK = 16'h0000;
  localparam logic [9:0]  PIX_NONE     = 10'h3FF;

  // Inclusive range test used for every window decode.
  function automatic logic in_range(input logic [9:0] val,
                                    input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping 10-bit raster axis counter with increment enable and a
// terminal-count flag that is high on the enabled cycle that wraps it.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter logic [9:0] MAX_CNT = H_TOTAL_DEF - 10'd1
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic       en,
  output logic [9:0] cnt,
  output logic       tc
);

  assign tc = en && (cnt == MAX_CNT);

  // Count up on enable, returning to zero on the same edge as the terminal count.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= 10'd0;
    end else if (en) begin
      cnt <= tc ? 10'd0 : cnt + 10'd1;
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: horizontal/vertical counters, active-low
// syncs, pixel requests issued one cycle ahead of the active window, and
// RGB565 gating. Optional macro VGA_TIMING_FRAME_CNT_EN adds the
// frame_start pulse and the 16-bit frame counter.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter logic [9:0] H_SYNC  = H_SYNC_DEF,
  parameter logic [9:0] H_BACK  = H_BACK_DEF,
  parameter logic [9:0] H_VALID = H_VALID_DEF,
  parameter logic [9:0] H_FRONT = H_FRONT_DEF,
  parameter logic [9:0] V_SYNC  = V_SYNC_DEF,
  parameter logic [9:0] V_BACK  = V_BACK_DEF,
  parameter logic [9:0] V_VALID = V_VALID_DEF,
  parameter logic [9:0] V_FRONT = V_FRONT_DEF
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic        frame_start,
  output logic [15:0] frame_cnt
`endif
);

  localparam logic [9:0] H_TOTAL     = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam logic [9:0] V_TOTAL     = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam logic [9:0] H_ACT_START = H_SYNC + H_BACK;
  localparam logic [9:0] H_ACT_END   = H_ACT_START + H_VALID - 10'd1;
  localparam logic [9:0] H_REQ_START = H_ACT_START - 10'd1;
  localparam logic [9:0] H_REQ_END   = H_ACT_END - 10'd1;
  localparam logic [9:0] V_ACT_START = V_SYNC + V_BACK;
  localparam logic [9:0] V_ACT_END   = V_ACT_START + V_VALID - 10'd1;

  logic [9:0] cnt_h;
  logic [9:0] cnt_v;
  logic       h_tc;
  logic       v_act;
  logic       rgb_valid;
  logic       pix_req;

  // Horizontal counter runs every pixel clock.
  vga_axis_counter #(.MAX_CNT(H_TOTAL - 10'd1)) u_h_cnt (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .en        (1'b1),
    .cnt       (cnt_h),
    .tc        (h_tc)
  );

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic v_tc;

  // Vertical counter advances once per line; its terminal count marks the frame wrap.
  vga_axis_counter #(.MAX_CNT(V_TOTAL - 10'd1)) u_v_cnt (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .en        (h_tc),
    .cnt       (cnt_v),
    .tc        (v_tc)
  );

  logic        started;
  logic [15:0] frame_cnt_q;

  // Remember that at least one edge has passed since reset, so the reset-time 0/0 is not a frame start.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) started <= 1'b0;
    else            started <= 1'b1;
  end

  // Count completed frames on the edge where both counters wrap.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  frame_cnt_q <= 16'd0;
    else if (v_tc)   frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign frame_start = started && (cnt_h == 10'd0) && (cnt_v == 10'd0);
  assign frame_cnt   = frame_cnt_q;
`else
  // Vertical counter advances once per line; the frame-wrap flag has no consumer here.
  vga_axis_counter #(.MAX_CNT(V_TOTAL - 10'd1)) u_v_cnt (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .en        (h_tc),
    .cnt       (cnt_v),
    .tc        ()
  );
`endif

  // Syncs and windows are pure decodes of the counter registers.
  assign hsync     = (cnt_h >= H_SYNC);
  assign vsync     = (cnt_v >= V_SYNC);
  assign v_act     = in_range(cnt_v, V_ACT_START, V_ACT_END);
  assign rgb_valid = v_act && in_range(cnt_h, H_ACT_START, H_ACT_END);
  assign pix_req   = v_act && in_range(cnt_h, H_REQ_START, H_REQ_END);

  // Coordinates are only subtracted inside the request window, so they never underflow.
  assign pix_x = pix_req ? (cnt_h - H_REQ_START) : PIX_NONE;
  assign pix_y = pix_req ? (cnt_v - V_ACT_START) : PIX_NONE;
  assign rgb   = rgb_valid ? pix_data : RGB565_BLACK;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Testbench for vga_timing_ctrl. Uses a reduced raster so whole frames fit
// in a short run; expected values come from position arithmetic on the
// number of clock edges since reset release.
module tb_vga_timing_ctrl;

  localparam int HS = 5;
  localparam int HB = 3;
  localparam int HV = 16;
  localparam int HF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VV = 6;
  localparam int VF = 2;
  localparam int HT = HS + HB + HV + HF;
  localparam int VT = VS + VB + VV + VF;
  localparam int FT = HT * VT;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [15:0] pix_data = 16'h0000;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        hsync;
  logic        vsync;
  logic [15:0] rgb;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic        frame_start;
  logic [15:0] frame_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;
  int k = 0;
  int mode = 0;
  int n_hlow, n_vlow, n_req, n_white, n_fstart;

  typedef struct {
    int          steps;
    logic [15:0] data;
    logic        hs;
    logic        vs;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] rgb;
  } vec_t;

  vec_t tbl[$];

  vga_timing_ctrl #(
    .H_SYNC (10'(HS)), .H_BACK (10'(HB)), .H_VALID(10'(HV)), .H_FRONT(10'(HF)),
    .V_SYNC (10'(VS)), .V_BACK (10'(VB)), .V_VALID(10'(VV)), .V_FRONT(10'(VF))
  ) dut (
    .vga_clk     (vga_clk),
    .sys_rst_n   (sys_rst_n),
    .pix_data    (pix_data),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
`endif
  );

  always #5 vga_clk = ~vga_clk;

  // Reference raster position after n edges since reset release.
  function automatic int hpos(input int n);
    return n % HT;
  endfunction

  function automatic int vpos(input int n);
    return (n / HT) % VT;
  endfunction

  function automatic bit line_active(input int n);
    return (vpos(n) >= VS + VB) && (vpos(n) < VS + VB + VV);
  endfunction

  function automatic bit is_valid(input int n);
    return line_active(n) && (hpos(n) >= HS + HB) && (hpos(n) < HS + HB + HV);
  endfunction

  function automatic bit is_req(input int n);
    return line_active(n) && (hpos(n) >= HS + HB - 1) && (hpos(n) < HS + HB + HV - 1);
  endfunction

  function automatic logic [9:0] exp_x(input int n);
    return is_req(n) ? 10'(hpos(n) - (HS + HB - 1)) : 10'h3FF;
  endfunction

  function automatic logic [9:0] exp_y(input int n);
    return is_req(n) ? 10'(vpos(n) - (VS + VB)) : 10'h3FF;
  endfunction

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at k=%0d: got %h, expected %h", name, k, act, exp);
    end
  endtask

  task automatic check_all();
    check_output("hsync", {15'd0, hsync}, {15'd0, hpos(k) >= HS});
    check_output("vsync", {15'd0, vsync}, {15'd0, vpos(k) >= VS});
    check_output("pix_x", {6'd0, pix_x}, {6'd0, exp_x(k)});
    check_output("pix_y", {6'd0, pix_y}, {6'd0, exp_y(k)});
    check_output("rgb", rgb, is_valid(k) ? pix_data : 16'h0000);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check_output("frame_start", {15'd0, frame_start}, {15'd0, (k > 0) && (k % FT == 0)});
    check_output("frame_cnt", frame_cnt, 16'(k / FT));
`endif
  endtask

  // Assert reset between edges, hold it over an edge, release on a falling edge (k = 0 afterwards).
  task automatic apply_reset();
    @(posedge vga_clk);
    #2 sys_rst_n = 1'b0;
    @(negedge vga_clk);
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    k = 0;
  endtask

  // Advance n edges; the picture-stage model returns data one cycle after each request.
  task automatic apply_stimulus(input int n, input bit chk_each);
    repeat (n) begin
      @(posedge vga_clk);
      #1;
      k++;
      case (mode)
        0:       pix_data = {6'd0, exp_x(k - 1)};
        1:       pix_data = 16'hFFFF;
        2:       pix_data = 16'($urandom);
        default: pix_data = pix_data;
      endcase
      @(negedge vga_clk);
      if (chk_each) check_all();
      if (!hsync) n_hlow++;
      if (!vsync) n_vlow++;
      if (pix_x != 10'h3FF) n_req++;
      if (rgb == 16'hFFFF) n_white++;
`ifdef VGA_TIMING_FRAME_CNT_EN
      if (frame_start) n_fstart++;
`endif
    end
  endtask

  task automatic clear_tallies();
    n_hlow = 0; n_vlow = 0; n_req = 0; n_white = 0;
  endtask

  task automatic mid_frame_reset(input int pos);
    mode = 1;
    apply_stimulus(pos, 1'b1);
    #2 sys_rst_n = 1'b0;
    #1;
    check_output("rst_hsync", {15'd0, hsync}, 16'd0);
    check_output("rst_vsync", {15'd0, vsync}, 16'd0);
    check_output("rst_pix_x", {6'd0, pix_x}, 16'h03FF);
    check_output("rst_pix_y", {6'd0, pix_y}, 16'h03FF);
    check_output("rst_rgb", rgb, 16'h0000);
    @(posedge vga_clk);
    #1;
    check_output("rst_hold_hsync", {15'd0, hsync}, 16'd0);
    check_output("rst_hold_pix_x", {6'd0, pix_x}, 16'h03FF);
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    k = 0;
    check_all();
    mode = 2;
    apply_stimulus(FT + 5, 1'b1);
  endtask

  initial begin
    // {steps, pix_data, hsync, vsync, pix_x, pix_y, rgb} for the reduced raster
    tbl.push_back('{0,   16'hABCD, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000});
    tbl.push_back('{4,   16'hABCD, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000});
    tbl.push_back('{5,   16'hABCD, 1'b1, 1'b0, 10'h3FF, 10'h3FF, 16'h0000});
    tbl.push_back('{25,  16'hABCD, 1'b1, 1'b0, 10'h3FF, 10'h3FF, 16'h0000});
    tbl.push_back('{26,  16'hABCD, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000});
    tbl.push_back('{52,  16'hABCD, 1'b0, 1'b1, 10'h3FF, 10'h3FF, 16'h0000});
    tbl.push_back('{111, 16'hABCD, 1'b1, 1'b1, 10'h3FF, 10'h3FF, 16'h0000});
    tbl.push_back('{137, 16'hABCD, 1'b1, 1'b1, 10'd0,   10'd0,   16'h0000});
    tbl.push_back('{138, 16'hABCD, 1'b1, 1'b1, 10'd1,   10'd0,   16'hABCD});
    tbl.push_back('{152, 16'hABCD, 1'b1, 1'b1, 10'd15,  10'd0,   16'hABCD});
    tbl.push_back('{153, 16'hABCD, 1'b1, 1'b1, 10'h3FF, 10'h3FF, 16'hABCD});
    tbl.push_back('{154, 16'hABCD, 1'b1, 1'b1, 10'h3FF, 10'h3FF, 16'h0000});
    tbl.push_back('{282, 16'hABCD, 1'b1, 1'b1, 10'd15,  10'd5,   16'hABCD});
    tbl.push_back('{293, 16'hABCD, 1'b1, 1'b1, 10'h3FF, 10'h3FF, 16'h0000});
    tbl.push_back('{337, 16'hABCD, 1'b1, 1'b1, 10'h3FF, 10'h3FF, 16'h0000});
    tbl.push_back('{338, 16'hABCD, 1'b0, 1'b0, 10'h3FF, 10'h3FF, 16'h0000});
    tbl.push_back('{475, 16'hABCD, 1'b1, 1'b1, 10'd0,   10'd0,   16'h0000});

    $display("[TB] table vectors");
    for (int i = 0; i < tbl.size(); i++) begin
      mode = 3;
      pix_data = tbl[i].data;
      apply_reset();
      apply_stimulus(tbl[i].steps, 1'b0);
      check_output($sformatf("tbl%0d_hsync", i), {15'd0, hsync}, {15'd0, tbl[i].hs});
      check_output($sformatf("tbl%0d_vsync", i), {15'd0, vsync}, {15'd0, tbl[i].vs});
      check_output($sformatf("tbl%0d_pix_x", i), {6'd0, pix_x}, {6'd0, tbl[i].x});
      check_output($sformatf("tbl%0d_pix_y", i), {6'd0, pix_y}, {6'd0, tbl[i].y});
      check_output($sformatf("tbl%0d_rgb", i), rgb, tbl[i].rgb);
    end

    $display("[TB] free-run frames against reference model");
    n_fstart = 0;
    pix_data = 16'h0000;
    apply_reset();
    check_all();
    for (int f = 0; f < 3; f++) begin
      mode = f;
      clear_tallies();
      apply_stimulus(FT, 1'b1);
      check_output($sformatf("frame%0d_hsync_low", f), 16'(n_hlow), 16'(HS * VT));
      check_output($sformatf("frame%0d_vsync_low", f), 16'(n_vlow), 16'(VS * HT));
      check_output($sformatf("frame%0d_requests", f), 16'(n_req), 16'(HV * VV));
      if (f == 1) check_output("frame1_white_pixels", 16'(n_white), 16'(HV * VV));
    end
`ifdef VGA_TIMING_FRAME_CNT_EN
    check_output("frame_start_pulses", 16'(n_fstart), 16'd3);
    check_output("frame_cnt_after_3", frame_cnt, 16'd3);
`endif

    $display("[TB] asynchronous reset mid-frame");
    mid_frame_reset(8 * HT + 12);
    mid_frame_reset(int'($urandom_range(1, FT - 1)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
